tp_sequencer: RTL and testbench
===============================

// Module: tp_sequencer
// PURPOSE
//  Timepulse sequencer for the NOR-gate timing logic: generates the one-hot
//  T01..T12 timepulse ring, with a phase strobe, that sequences the NOR-gate
//  datapath one memory cycle (MCT) at a time.
//  Supports free-running, stop-at-MCT-boundary and monitor single-step
//  operation, and counts completed MCTs.
// PARAMETERS
//  NUM_TP      12  timepulses per MCT (one-hot width of tp), >=2
//  CYC_PER_TP   4  clk cycles per timepulse; even, >=2
//  MCT_WIDTH   16  width of the MCT counter; wraps modulo 2**MCT_WIDTH
// PORTS
//  clk        in   1          single system clock; all state changes on rising edge
//  rst        in   1          synchronous reset, ACTIVE-LOW (rst==0 at an edge resets)
//  run        in   1          level: 1 = free-run MCTs, 0 = stop at next MCT boundary
//  step_req   in   1          monitor single-step request (level, 4-phase handshake)
//  step_ack   out  1          single-step completion acknowledge
//  tp         out  NUM_TP     one-hot timepulse; bit0 = T01; all-zero when idle
//  phase      out  1          0 = first half of current TP, 1 = second half
//  mct_done   out  1          1-cycle pulse in the last clk cycle of T(NUM_TP)
//  mct_count  out  MCT_WIDTH  completed-MCT count
//  stopped    out  1          1 when IDLE (no MCT in progress)
// BEHAVIOUR
//  - All outputs registered. Reset values: tp=0, phase=0, mct_done=0,
//    mct_count=0, step_ack=0, stopped=1, FSM=IDLE, cycle and TP counters=0.
//  - Reset applies on any edge with rst==0, including mid-MCT: the
//    sequence is abandoned, the partial MCT is not counted, and mct_done
//    does not pulse.
//  - FSM states: IDLE, RUN, STOP_PEND, STEP, ACK.
//  - IDLE: run==1 sampled at edge k -> RUN; tp=T01, phase=0, stopped=0 from
//    edge k+1. run has priority over step_req when both are high.
//  - Sequencing (RUN/STOP_PEND/STEP): each TP lasts exactly CYC_PER_TP cycles.
//    phase=0 for the first CYC_PER_TP/2 cycles and 1 for the remainder.
//    The TP then advances one bit. One MCT = NUM_TP*CYC_PER_TP cycles.
//  - Last cycle of T(NUM_TP): mct_done=1 and mct_count increments (wraps
//    to 0 from all-ones).
//  - RUN: run==0 sampled -> STOP_PEND; the current MCT always completes.
//    If run==1 at the MCT end, T01 follows T(NUM_TP) with no gap cycle.
//  - STOP_PEND: run==1 again before the MCT end -> RUN, with no disturbance
//    to tp. At the MCT end with run==0 -> IDLE: tp=0, stopped=1 on the next
//    cycle.
//  - Exactly one tp bit is high whenever stopped==0; tp==0 whenever stopped==1.
// CONFIGURATION
//  Macro TP_SEQ_STEP_EN:
//  - Defined: single-step is supported.
//    - IDLE with run==0 and step_req==1 -> STEP, which runs exactly one MCT.
//    - At its end -> ACK: tp=0, stopped=1, step_ack=1, held while step_req==1.
//    - step_req==0 in ACK -> step_ack=0 next cycle, then IDLE. No new step
//      starts until step_req has been seen low.
//    - run==1 during STEP: the MCT completes, then RUN continues with no gap
//      and no ack.
//    - run==1 in ACK is ignored until the handshake closes.
//  - Not defined: step_req is ignored, step_ack is tied 0, and the STEP/ACK
//    states do not exist.
// TESTING
//  1 rst=0 for 2 edges, run=0 -> tp=0, phase=0, stopped=1, mct_count=0,
//    step_ack=0, mct_done=0.
//  2 Defaults, run=1 held: tp=12'h001 one cycle after run is sampled, shifting
//    left every 4 cycles; phase pattern 0,0,1,1; mct_done every 48 cycles;
//    mct_count=3 after 144 cycles.
//  3 run=1, then run=0 during T05 -> T12 completes, mct_count=1, tp=0,
//    stopped=1; no further mct_done.
//  4 run dropped in T03 and raised in T09 -> no gap; T01 directly follows T12.
//  5 TP_SEQ_STEP_EN, run=0, step_req=1 -> exactly one 48-cycle MCT, then
//    step_ack=1 held; step_req=0 -> step_ack=0 next cycle; mct_count=1.
//  6 MCT_WIDTH=2, run for 5 MCTs -> mct_count 1,2,3,0,1. Reset in T07 ->
//    next cycle tp=0, mct_count=0, mct_done=0.

Source files
------------

// File: rtl/tp_sequencer.sv
// tp_sequencer: one-hot T01..T(NUM_TP) timepulse ring with phase strobe, run/stop and MCT counting.
// Define TP_SEQ_STEP_EN to add the monitor single-step handshake (step_req/step_ack).
module tp_sequencer #(
  parameter int NUM_TP     = 12,
  parameter int CYC_PER_TP = 4,
  parameter int MCT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step_req,
  output logic                 step_ack,
  output logic [NUM_TP-1:0]    tp,
  output logic                 phase,
  output logic                 mct_done,
  output logic [MCT_WIDTH-1:0] mct_count,
  output logic                 stopped
);
  localparam int CW = $clog2(CYC_PER_TP);
  localparam int IW = $clog2(NUM_TP);
  localparam logic [CW-1:0] CYC_LAST = CW'(CYC_PER_TP - 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(CYC_PER_TP / 2);
  localparam logic [IW-1:0] TP_LAST  = IW'(NUM_TP - 1);
`ifdef TP_SEQ_STEP_EN
  typedef enum logic [2:0] {IDLE, RUN, STOP_PEND, STEP, ACK} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;
  logic unused_step_req;
  assign unused_step_req = step_req;
`endif
  state_t state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [IW-1:0] idx, idx_n;
  logic seq, seq_n, mct_end, done_n, ack_n;
`ifdef TP_SEQ_STEP_EN
  assign seq   = state == RUN || state == STOP_PEND || state == STEP;
  assign seq_n = state_n == RUN || state_n == STOP_PEND || state_n == STEP;
  assign ack_n = state_n == ACK;
`else
  assign seq   = state == RUN || state == STOP_PEND;
  assign seq_n = state_n == RUN || state_n == STOP_PEND;
  assign ack_n = 1'b0;
`endif
  assign mct_end = seq && cyc == CYC_LAST && idx == TP_LAST;
  always_comb begin
    state_n = state;
    case (state)
`ifdef TP_SEQ_STEP_EN
      IDLE:           state_n = run ? RUN : step_req ? STEP : IDLE;
      STEP:           state_n = mct_end ? (run ? RUN : ACK) : STEP;
      ACK:            state_n = step_req ? ACK : IDLE;
`else
      IDLE:           state_n = run ? RUN : IDLE;
`endif
      RUN, STOP_PEND: state_n = run ? RUN : mct_end ? IDLE : STOP_PEND;
      default:        state_n = IDLE;
    endcase
  end
  // counters hold the position that will be shown after the next edge; a fresh MCT starts at T01 cycle 0
  assign cyc_n  = (seq && seq_n && cyc != CYC_LAST) ? cyc + 1'b1 : '0;
  assign idx_n  = !(seq && seq_n) ? '0 : cyc != CYC_LAST ? idx : idx == TP_LAST ? '0 : idx + 1'b1;
  assign done_n = seq_n && cyc_n == CYC_LAST && idx_n == TP_LAST;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cyc       <= '0;
      idx       <= '0;
      tp        <= '0;
      phase     <= 1'b0;
      mct_done  <= 1'b0;
      mct_count <= '0;
      step_ack  <= 1'b0;
      stopped   <= 1'b1;
    end else begin
      state     <= state_n;
      cyc       <= cyc_n;
      idx       <= idx_n;
      tp        <= seq_n ? NUM_TP'(1) << idx_n : '0;
      phase     <= seq_n && cyc_n >= CYC_HALF;
      mct_done  <= done_n;
      mct_count <= mct_count + MCT_WIDTH'(done_n);
      step_ack  <= ack_n;
      stopped   <= !seq_n;
    end
  end
endmodule

// File: tb/tb_tp_sequencer.sv
// tb_tp_sequencer: random run/step/reset stimulus scored against a cycle-position model of the sequencer.
module tb_tp_sequencer;
  localparam int N  = 12;
  localparam int C  = 4;
  localparam int NC = N * C;
  localparam int MW = 2;
`ifdef TP_SEQ_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_ACK = 3;
  typedef struct packed {
    logic [N-1:0]  tp;
    logic          phase;
    logic          done;
    logic [MW-1:0] cnt;
    logic          ack;
    logic          stopped;
  } obs_t;
  logic clk = 1'b0, rst = 1'b0, run = 1'b0, step_req = 1'b0;
  logic step_ack, phase, mct_done, stopped;
  logic [N-1:0] tp;
  logic [MW-1:0] mct_count;
  obs_t q[$];
  obs_t e, got;
  int checks = 0, passes = 0, ncyc = 0;
  int m_mode = M_IDLE, m_t = 0, m_cnt = 0;
  logic r_run = 1'b0, r_step = 1'b0;
  logic seen = 1'b0;
  tp_sequencer #(.NUM_TP(N), .CYC_PER_TP(C), .MCT_WIDTH(MW)) dut (
    .clk(clk), .rst(rst), .run(run), .step_req(step_req), .step_ack(step_ack),
    .tp(tp), .phase(phase), .mct_done(mct_done), .mct_count(mct_count), .stopped(stopped)
  );
  always #5 clk = ~clk;
  task automatic model();
    obs_t x;
    if (!rst) begin
      m_mode = M_IDLE; m_t = 0; m_cnt = 0;
    end else if (m_mode == M_IDLE) begin
      if (run) begin m_mode = M_RUN; m_t = 0; end
      else if (STEP_EN && step_req) begin m_mode = M_STEP; m_t = 0; end
    end else if (m_mode == M_ACK) begin
      if (!step_req) m_mode = M_IDLE;
    end else if (m_t == NC - 1) begin
      if (run) begin m_mode = M_RUN; m_t = 0; end
      else m_mode = (m_mode == M_STEP) ? M_ACK : M_IDLE;
    end else begin
      m_t++;
      if (m_t == NC - 1) m_cnt = (m_cnt + 1) % (1 << MW);
    end
    x = '0;
    x.cnt = MW'(m_cnt);
    x.ack = m_mode == M_ACK;
    x.stopped = !(m_mode == M_RUN || m_mode == M_STEP);
    if (!x.stopped) begin
      x.tp = N'(1) << (m_t / C);
      x.phase = (m_t % C) >= C / 2;
      x.done = m_t == NC - 1;
    end
    q.push_back(x);
  endtask
  task automatic drive(input logic r, input logic rn, input logic sr);
    @(negedge clk);
    rst = r; run = rn; step_req = sr;
    model();
  endtask
  always @(posedge clk) begin
    #1;
    ncyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = '{tp, phase, mct_done, mct_count, step_ack, stopped};
      checks++;
      if (got === e) passes++;
      else $display("FAIL outputs@cycle%0d: got tp=%h phase=%b done=%b cnt=%0d ack=%b stopped=%b, required tp=%h phase=%b done=%b cnt=%0d ack=%b stopped=%b",
                    ncyc, got.tp, got.phase, got.done, got.cnt, got.ack, got.stopped,
                    e.tp, e.phase, e.done, e.cnt, e.ack, e.stopped);
    end
  end
  initial begin
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (tp === '0 && phase === 1'b0 && stopped === 1'b1 && mct_count === '0 && step_ack === 1'b0 && mct_done === 1'b0) passes++;
    else $display("FAIL reset state: tp=%h phase=%b stopped=%b cnt=%0d ack=%b done=%b, required tp=0 phase=0 stopped=1 cnt=0 ack=0 done=0",
                  tp, phase, stopped, mct_count, step_ack, mct_done);
    repeat (200) drive(1'b1, 1'b1, 1'b0);
    repeat (60) drive(1'b1, 1'b0, 1'b0);
    repeat (16) drive(1'b1, 1'b1, 1'b0);
    repeat (20) drive(1'b1, 1'b0, 1'b0);
    repeat (24) drive(1'b1, 1'b1, 1'b0);
    repeat (60) drive(1'b1, 1'b0, 1'b0);
    repeat (80) drive(1'b1, 1'b0, 1'b1);
    repeat (10) drive(1'b1, 1'b0, 1'b0);
    repeat (30) drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    repeat (10) drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) r_run = !r_run;
      if ($urandom_range(29) == 0) r_step = !r_step;
      drive($urandom_range(599) != 0, r_run, r_step);
    end
    for (int i = 0; i < 2 * NC + 4 && !seen; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      seen = mct_done;
    end
    checks++;
    if (seen) passes++;
    else $display("FAIL timeout: no mct_done within %0d cycles of run=1", 2 * NC + 4);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
